// File: rtl/lamp_relay_sequencer.sv
// Lamp/relay sequencer: one-hot self-test walk on start1, then staggered relay
// turn-on in RUN once start2 is seen; a fault latches all relays off until cleared.
module lamp_relay_sequencer #(
  parameter int         CH_NUM        = 4,
  parameter logic [7:0] TEST_TICKS    = 8'd25,
  parameter logic [7:0] STAGGER_TICKS = 8'd10
) (
  input  logic              i_clk_50,
  input  logic              i_rst_n,
  input  logic              i_start1,
  input  logic              i_start2,
  input  logic [CH_NUM-1:0] i_cmd,
  input  logic              i_fault,
  input  logic              i_fault_clr,
  output logic [CH_NUM-1:0] o_relay,
  output logic              o_test_busy,
  output logic              o_ready,
  output logic              o_fault,
  output logic [2:0]        o_state
);

  // state | meaning
  // IDLE  | relays off, waiting for start1
  // TEST  | one-hot walk, each channel lit TEST_TICKS cycles
  // WAIT2 | self-test done, waiting for start2
  // RUN   | relays follow i_cmd, turn-ons spaced by STAGGER_TICKS
  // FAULT | relays forced off until i_fault_clr with i_fault low
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TEST  = 3'd1,
    ST_WAIT2 = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [2:0] LAST_CH = 3'(CH_NUM - 1);
  localparam logic [CH_NUM-1:0] CH0_ONEHOT = {{(CH_NUM-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [CH_NUM-1:0] relay_nxt;
  logic [2:0]        ch_idx, ch_idx_nxt;
  logic [7:0]        tick_cnt, tick_nxt;
  logic [7:0]        stag_cnt, stag_nxt;
  logic [CH_NUM-1:0] pending, grant;
  logic              grant_found;

  // Lowest-index pending channel wins the next turn-on slot.
  always_comb begin
    pending     = i_cmd & ~o_relay;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (pending[i] && !grant_found) begin
        grant[i]    = 1'b1;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    relay_nxt  = o_relay;
    ch_idx_nxt = ch_idx;
    tick_nxt   = tick_cnt;
    stag_nxt   = stag_cnt;

    if (i_fault && state != ST_FAULT) begin
      state_nxt  = ST_FAULT;
      relay_nxt  = '0;
      ch_idx_nxt = '0;
      tick_nxt   = '0;
      stag_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          relay_nxt = '0;
          if (i_start1) begin
            state_nxt  = ST_TEST;
            relay_nxt  = CH0_ONEHOT;
            ch_idx_nxt = '0;
            tick_nxt   = '0;
          end
        end

        ST_TEST: begin
          if (tick_cnt == TEST_TICKS - 8'd1) begin
            tick_nxt = '0;
            if (ch_idx == LAST_CH) begin
              relay_nxt  = '0;
              ch_idx_nxt = '0;
              stag_nxt   = '0;
              state_nxt  = i_start2 ? ST_RUN : ST_WAIT2;
            end else begin
              ch_idx_nxt = ch_idx + 3'd1;
              relay_nxt  = o_relay << 1;
            end
          end else begin
            tick_nxt = tick_cnt + 8'd1;
          end
        end

        ST_WAIT2: begin
          relay_nxt = '0;
          if (i_start2) begin
            state_nxt = ST_RUN;
            stag_nxt  = '0;
          end
        end

        ST_RUN: begin
          // Offs apply immediately; at most one on per stagger window.
          relay_nxt = o_relay & i_cmd;
          if (stag_cnt == 8'd0) begin
            if (grant_found) begin
              relay_nxt = relay_nxt | grant;
              stag_nxt  = STAGGER_TICKS - 8'd1;
            end
          end else begin
            stag_nxt = stag_cnt - 8'd1;
          end
        end

        ST_FAULT: begin
          relay_nxt = '0;
          if (i_fault_clr && !i_fault) state_nxt = ST_IDLE;
        end

        default: begin
          state_nxt = ST_IDLE;
          relay_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_50) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_relay     <= '0;
      ch_idx      <= '0;
      tick_cnt    <= '0;
      stag_cnt    <= '0;
      o_test_busy <= 1'b0;
      o_ready     <= 1'b0;
      o_fault     <= 1'b0;
      o_state     <= 3'd0;
    end else begin
      state       <= state_nxt;
      o_relay     <= relay_nxt;
      ch_idx      <= ch_idx_nxt;
      tick_cnt    <= tick_nxt;
      stag_cnt    <= stag_nxt;
      o_test_busy <= (state_nxt == ST_TEST);
      o_ready     <= (state_nxt == ST_RUN);
      o_fault     <= (state_nxt == ST_FAULT);
      o_state     <= state_nxt;
    end
  end

endmodule

// File: tb/tb_lamp_relay_sequencer.sv
// Directed bench for lamp_relay_sequencer: self-test walk, staggered RUN,
// fault latch/clear, direct TEST->RUN and mid-RUN reset.
module tb_lamp_relay_sequencer;

  logic       i_clk_50 = 1'b0;
  logic       i_rst_n;
  logic       i_start1, i_start2;
  logic [3:0] i_cmd;
  logic       i_fault, i_fault_clr;
  logic [3:0] o_relay;
  logic       o_test_busy, o_ready, o_fault;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  lamp_relay_sequencer #(
    .CH_NUM(4), .TEST_TICKS(8'd25), .STAGGER_TICKS(8'd10)
  ) dut (
    .i_clk_50(i_clk_50), .i_rst_n(i_rst_n), .i_start1(i_start1),
    .i_start2(i_start2), .i_cmd(i_cmd), .i_fault(i_fault),
    .i_fault_clr(i_fault_clr), .o_relay(o_relay), .o_test_busy(o_test_busy),
    .o_ready(o_ready), .o_fault(o_fault), .o_state(o_state)
  );

  always #10 i_clk_50 = ~i_clk_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk_50);
    #1;
  endtask

  initial begin
    logic [3:0] exp_r;
    logic       saw_wait2;

    i_rst_n = 1'b0; i_start1 = 1'b0; i_start2 = 1'b0;
    i_cmd = 4'b0000; i_fault = 1'b0; i_fault_clr = 1'b0;
    step(3);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_relay", 32'(o_relay), 32'd0);
    chk("rst_flags", 32'({o_test_busy, o_ready, o_fault}), 32'd0);

    i_rst_n = 1'b1;
    step(10);
    chk("idle_hold", 32'(o_state), 32'd0);

    // Self-test walk: each channel for 25 cycles.
    i_start1 = 1'b1;
    i_cmd = 4'b1111;
    step(1);
    chk("test_state", 32'(o_state), 32'd1);
    chk("test_busy", 32'(o_test_busy), 32'd1);
    for (int ch = 0; ch < 4; ch++) begin
      exp_r = 4'b0001 << ch;
      chk("test_first", 32'(o_relay), 32'(exp_r));
      step(24);
      chk("test_last", 32'(o_relay), 32'(exp_r));
      step(1);
    end
    chk("test_end_relay", 32'(o_relay), 32'd0);
    chk("wait2_state", 32'(o_state), 32'd2);
    chk("wait2_busy", 32'(o_test_busy), 32'd0);
    i_cmd = 4'b0000;
    step(100);
    chk("wait2_hold", 32'(o_state), 32'd2);

    // RUN with staggered turn-on.
    i_start2 = 1'b1;
    step(1);
    chk("run_state", 32'(o_state), 32'd3);
    chk("run_ready", 32'(o_ready), 32'd1);
    chk("run_relay0", 32'(o_relay), 32'd0);
    step(9);
    i_cmd = 4'b1111;
    step(1);
    chk("stag_on0", 32'(o_relay), 32'b0001);
    step(9);
    chk("stag_hold0", 32'(o_relay), 32'b0001);
    step(1);
    chk("stag_on1", 32'(o_relay), 32'b0011);
    step(10);
    chk("stag_on2", 32'(o_relay), 32'b0111);
    step(10);
    chk("stag_on3", 32'(o_relay), 32'b1111);
    step(10);
    chk("all_on_hold", 32'(o_relay), 32'b1111);

    // Several offs at once, then re-request with the stagger already expired.
    i_cmd = 4'b0101;
    step(1);
    chk("multi_off", 32'(o_relay), 32'b0101);
    i_cmd = 4'b1111;
    step(1);
    chk("reon_ch1", 32'(o_relay), 32'b0111);
    step(9);
    chk("reon_wait", 32'(o_relay), 32'b0111);
    step(1);
    chk("reon_ch3", 32'(o_relay), 32'b1111);
    step(10);

    // Off and on on different channels in the same cycle.
    i_cmd = 4'b1110;
    step(1);
    chk("off_ch0", 32'(o_relay), 32'b1110);
    step(10);
    i_cmd = 4'b0111;
    step(1);
    chk("off_on_same", 32'(o_relay), 32'b0111);

    // Request withdrawn before its slot is dropped.
    i_cmd = 4'b1111;
    step(3);
    chk("pending_wait", 32'(o_relay), 32'b0111);
    i_cmd = 4'b0111;
    step(12);
    chk("withdrawn", 32'(o_relay), 32'b0111);

    // Reset mid-RUN.
    i_rst_n = 1'b0;
    step(1);
    chk("midrst_state", 32'(o_state), 32'd0);
    chk("midrst_relay", 32'(o_relay), 32'd0);
    chk("midrst_flags", 32'({o_test_busy, o_ready, o_fault}), 32'd0);

    // Restart test; fault during ch2.
    i_rst_n = 1'b1;
    i_cmd = 4'b0000;
    step(1);
    chk("retest_state", 32'(o_state), 32'd1);
    step(50);
    chk("on_ch2", 32'(o_relay), 32'b0100);
    i_fault = 1'b1;
    step(1);
    chk("fault_state", 32'(o_state), 32'd4);
    chk("fault_relay", 32'(o_relay), 32'd0);
    chk("fault_flag", 32'(o_fault), 32'd1);
    chk("fault_busy", 32'(o_test_busy), 32'd0);
    i_fault_clr = 1'b1;
    i_cmd = 4'b1111;
    step(3);
    chk("clr_blocked", 32'(o_state), 32'd4);
    chk("fault_cmd_ign", 32'(o_relay), 32'd0);
    i_fault = 1'b0;
    i_fault_clr = 1'b0;
    step(1);
    chk("fault_latched", 32'(o_state), 32'd4);
    i_fault_clr = 1'b1;
    step(1);
    chk("clr_idle", 32'(o_state), 32'd0);
    chk("clr_flag", 32'(o_fault), 32'd0);
    i_fault_clr = 1'b0;
    step(1);
    chk("restart_state", 32'(o_state), 32'd1);
    chk("restart_ch0", 32'(o_relay), 32'b0001);

    // start2 already high: TEST goes straight to RUN.
    saw_wait2 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (o_state == 3'd2) saw_wait2 = 1'b1;
    end
    chk("direct_run", 32'(o_state), 32'd3);
    chk("no_wait2", 32'(saw_wait2), 32'd0);
    step(1);
    chk("direct_run_on0", 32'(o_relay), 32'b0001);

    // Fault from RUN drops every relay at once.
    i_fault = 1'b1;
    step(1);
    chk("run_fault", 32'({o_state, o_relay}), 32'({3'd4, 4'b0000}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lamp_relay_sequencer.md
Name: lamp_relay_sequencer

Overview:
- Downstream consumer of the power-up start flags (start1 at 1 s, start2 at 5 s, both 50 Hz domain).
- On start1, runs a one-hot lamp/relay self-test walk.
- On start2 plus test done, enters RUN: relay outputs follow commands, with staggered turn-on to limit inrush.
- A fault input forces all relays off until explicitly cleared.

Parameters:
- CH_NUM, 4, number of relay/lamp channels (2..8).
- TEST_TICKS, 8'd25, clk cycles each channel is lit during self-test (0.5 s at 50 Hz).
- STAGGER_TICKS, 8'd10, minimum cycles between two successive relay turn-ons in RUN (0.2 s); must be >= 1.

Ports:
- i_clk_50  in  1  50 Hz system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_start1  in  1  start flag 1 (level, stays high once set).
- i_start2  in  1  start flag 2 (level, stays high once set).
- i_cmd  in  CH_NUM  requested relay state per channel in RUN (1 = on).
- i_fault  in  1  external fault, level.
- i_fault_clr  in  1  fault acknowledge pulse/level.
- o_relay  out  CH_NUM  registered relay drive.
- o_test_busy  out  1  high while in TEST.
- o_ready  out  1  high while in RUN.
- o_fault  out  1  high while in FAULT.
- o_state  out  3  state code: IDLE=0, TEST=1, WAIT2=2, RUN=3, FAULT=4.

Behaviour:
- Interface: one clock i_clk_50; reset i_rst_n is synchronous and active-low.
- All outputs are registered.
- Reset (i_rst_n=0 at an edge) gives: state IDLE, o_relay=0, o_test_busy=0, o_ready=0, o_fault=0, o_state=0, channel index=0, tick counter=0, stagger counter=0. Reset mid-operation aborts immediately with the same values.
- Priority at each edge: reset > fault entry > normal transitions.
- Fault entry: i_fault=1 in any state except FAULT -> FAULT at that edge, o_relay=0, o_fault=1.
- IDLE:
  - o_relay=0.
  - i_start1=1 -> TEST at that edge, o_relay=1 (ch0), tick counter=0.
- TEST:
  - Exactly one relay on; channel n is held for exactly TEST_TICKS cycles, then channel n+1 at the next edge.
  - After channel CH_NUM-1 completes: o_relay=0, then RUN if i_start2=1, else WAIT2.
  - Total TEST duration is CH_NUM*TEST_TICKS cycles.
  - i_start2 and i_cmd are ignored during TEST.
- WAIT2:
  - o_relay=0.
  - i_start2=1 -> RUN, stagger counter=0.
- RUN:
  - Off: any channel with i_cmd=0 clears its o_relay bit at the next edge. Several offs may occur in the same cycle.
  - On: pending channels are i_cmd=1 and o_relay=0. When the stagger counter is 0, the lowest-index pending channel turns on at that edge and the counter loads STAGGER_TICKS-1. The counter decrements by 1 per cycle while nonzero.
  - At most one turn-on per STAGGER_TICKS cycles; simultaneous on-requests are served in ascending index order.
  - A request withdrawn before service is dropped with no turn-on.
  - An off and an on in the same cycle on different channels both apply.
- FAULT:
  - o_relay held 0; i_cmd is ignored.
  - i_fault_clr=1 with i_fault=0 -> IDLE with o_fault=0. Because i_start1 is still high, the self-test re-runs.
  - i_fault_clr while i_fault=1 has no effect.
- Counters saturate/wrap only within their own ranges; no counter exceeds 8 bits.
- o_test_busy = (state==TEST), o_ready = (state==RUN), o_fault = (state==FAULT), updated on the same edge as the state.

Test Plan:
- Reset release, i_start1 high at cycle 50 -> o_state=1 from that edge; o_relay = 0001/0010/0100/1000, each for 25 cycles; then 0000 and o_state=2 at cycle 150.
- i_start2 high at cycle 250 -> o_state=3, o_ready=1; i_cmd=1111 at cycle 260 -> relays turn on at cycles 260, 270, 280, 290 in order ch0..ch3.
- In RUN with o_relay=1111, i_cmd=0101 -> o_relay=0101 at the next edge; i_cmd back to 1111 -> ch1 on immediately (stagger expired), ch3 on 10 cycles later.
- i_fault=1 during TEST on ch2 -> o_relay=0000, o_state=4, o_fault=1 at that edge. i_fault_clr while i_fault=1 -> stays 4. i_fault=0 then i_fault_clr=1 -> IDLE, then TEST restarts at ch0.
- i_start2 already high when TEST ends -> direct transition to RUN, WAIT2 never visited. i_rst_n=0 mid-RUN -> all outputs 0 and o_state=0 at that edge.
